// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - I/D memory port arbiter with fixed-latency access sequencing; optional round-robin under MEM_ARB_RR_EN
module mem_port_arbiter #(
    parameter int LAT   = 1,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_sel,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             grant_d;
    logic             we_q;
    logic             pick_d;
    logic             start;

    assign start = (state == IDLE) && (i_req || d_req);

`ifdef MEM_ARB_RR_EN
    logic last_d;

    // Remember which side won the most recent arbitration (0 = I, 1 = D)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (start) begin
            last_d <= pick_d;
        end
    end

    // On a tie the side that did not win last time goes first
    assign pick_d = d_req && !(i_req && last_d);
`else
    // Load/store always wins a tie: it belongs to the older instruction
    assign pick_d = d_req;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: IDLE -> ACCESS (LAT cycles) -> RESP (ack) -> IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_req || d_req) state_nx = ACCESS;
            ACCESS:  if (cnt == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant, latched access attributes, latency counter and read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_d   <= 1'b0;
            we_q      <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            if (start) begin
                grant_d <= pick_d;
                cnt     <= CNT_W'(LAT - 1);
                if (pick_d) begin
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    we_q      <= d_we;
                end else begin
                    mem_addr <= i_addr;
                    we_q     <= 1'b0;
                end
            end else if (state == ACCESS) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else if (!we_q) begin
                    if (grant_d) begin
                        d_rdata <= mem_rdata;
                    end else begin
                        i_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    // Strobes decode directly from state so reset or RESP drops them at once
    assign mem_en  = (state == ACCESS);
    assign mem_we  = mem_en && we_q;
    assign mem_sel = grant_d;
    assign busy    = (state != IDLE);
    assign i_ack   = (state == RESP) && !grant_d;
    assign d_ack   = (state == RESP) && grant_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with transaction-level reference model
module tb_mem_port_arbiter;

    localparam int LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_sel;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_i_rdata;
    logic [31:0] m_d_rdata;
    bit          m_last_d;

    mem_port_arbiter #(.LAT(LAT), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_sel   (mem_sel),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one arbitrated access from the IDLE cycle (current negedge, requests
    // already driven) through ACCESS, RESP and the following IDLE bubble.
    task automatic serve(input logic [31:0] rd, input bit drop);
        bit          wd;
        bit          ewe;
        logic [31:0] ea;
        logic [31:0] ewd;
`ifdef MEM_ARB_RR_EN
        if (i_req && d_req) wd = !m_last_d;
        else                wd = d_req;
`else
        wd = d_req;
`endif
        ea  = wd ? d_addr : i_addr;
        ewe = wd ? d_we : 1'b0;
        ewd = d_wdata;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk("acc_busy", busy, 1);
            chk("acc_mem_en", mem_en, 1);
            chk("acc_mem_sel", mem_sel, wd);
            chk("acc_mem_addr", mem_addr, ea);
            chk("acc_mem_we", mem_we, ewe);
            if (ewe) chk("acc_mem_wdata", mem_wdata, ewd);
            chk("acc_acks", {i_ack, d_ack}, 0);
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_we    = 1'($urandom);
            if (drop && k == 2) begin
                if (wd) d_req = 1'b0;
                else    i_req = 1'b0;
            end
            mem_rdata = (k == LAT) ? rd : $urandom;
        end
        @(negedge clk);
        if (!ewe) begin
            if (wd) m_d_rdata = rd;
            else    m_i_rdata = rd;
        end
        chk("resp_i_ack", i_ack, !wd);
        chk("resp_d_ack", d_ack, wd);
        chk("resp_mem_en", mem_en, 0);
        chk("resp_mem_we", mem_we, 0);
        chk("resp_busy", busy, 1);
        chk("resp_i_rdata", i_rdata, m_i_rdata);
        chk("resp_d_rdata", d_rdata, m_d_rdata);
        if (wd) d_req = 1'b0;
        else    i_req = 1'b0;
        m_last_d  = wd;
        mem_rdata = $urandom;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_acks", {i_ack, d_ack}, 0);
        chk("idle_mem_en", mem_en, 0);
        chk("idle_mem_sel", mem_sel, wd);
    endtask

    initial begin
        int r;
        rst_n     = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        m_i_rdata = '0;
        m_d_rdata = '0;
        m_last_d  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_acks", {i_ack, d_ack}, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // Instruction fetch
        i_req  = 1'b1;
        i_addr = 32'h0040_0000;
        serve(32'h3C01_0040, 1'b0);
        chk("fetch_word", i_rdata, 32'h3C01_0040);

        // Store: d_rdata must stay untouched
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h1001_0004;
        d_wdata = 32'hDEAD_BEEF;
        serve($urandom, 1'b0);
        chk("store_d_rdata", d_rdata, 0);

        // Load with request dropped and address changed mid-access
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h1001_0008;
        serve(32'h1234_5678, 1'b1);
        chk("load_word", d_rdata, 32'h1234_5678);

        // Simultaneous requests: winner first, loser after the bubble
        i_req  = 1'b1;
        d_req  = 1'b1;
        d_we   = 1'b0;
        i_addr = 32'h0040_0004;
        d_addr = 32'h1001_000C;
        serve($urandom, 1'b0);
        serve($urandom, 1'b0);

        // Reset in the second ACCESS cycle of a load
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = $urandom;
        repeat (2) @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_mem_en", mem_en, 0);
        chk("abort_mem_sel", mem_sel, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_d_rdata", d_rdata, 0);
        chk("abort_i_rdata", i_rdata, 0);
        d_req = 1'b0;
        m_i_rdata = '0;
        m_d_rdata = '0;
        m_last_d  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_ack", {i_ack, d_ack}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", busy, 0);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = $urandom;
        serve($urandom, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            r       = $urandom_range(1, 3);
            i_req   = r[0];
            d_req   = r[1];
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_we    = 1'($urandom);
            serve($urandom, 1'($urandom));
            if (i_req || d_req) serve($urandom, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
